// File: rtl/tri_mux_rr_arbiter_if.sv
// Request/grant bundle between three requesters and the round-robin arbiter
// that steers the shared 3:1 mux select.
interface tri_mux_rr_arbiter_if;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       busy;

  // master: requester side; slave: arbiter side
  modport master (output req, input gnt, input sel, input busy);
  modport slave  (input req, output gnt, output sel, output busy);
endinterface

// File: rtl/tri_mux_rr_arbiter.sv
// Round-robin arbiter for a shared 3:1 mux with a bounded hold time.
// Grant, select and busy are all registered so the mux select never glitches.
module tri_mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tri_mux_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          busy_q, busy_d;

  // First set request bit found searching ptr, ptr+1, ptr+2 (mod 3).
  function automatic pick_t rr_pick(input logic [2:0] r, input logic [1:0] p);
    pick_t      res;
    logic [1:0] idx;
    res = '{found: 1'b0, idx: 2'd0};
    idx = p;
    for (int k = 0; k < 3; k++) begin
      if (!res.found && r[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return res;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  logic [1:0] owner;
  logic [1:0] next_ptr;
  logic [2:0] others;
  pick_t      idle_pick;
  pick_t      hand_pick;

  // In GRANT the registered select is the owner's index.
  assign owner     = sel_q;
  assign next_ptr  = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
  assign others    = bus.req & ~onehot(owner);
  assign idle_pick = rr_pick(bus.req, ptr_q);
  assign hand_pick = rr_pick(others, next_ptr);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;

    unique case (state_q)
      IDLE: begin
        if (idle_pick.found) begin
          gnt_d   = onehot(idle_pick.idx);
          sel_d   = idle_pick.idx;
          cnt_d   = CW'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[owner] || (cnt_q == HOLD_LIMIT && |others)) begin
          // Release or preemption: advance past the owner and hand over.
          ptr_d = next_ptr;
          if (hand_pick.found) begin
            gnt_d = onehot(hand_pick.idx);
            sel_d = hand_pick.idx;
            cnt_d = CW'(1);
          end else begin
            gnt_d   = 3'b000;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (cnt_q != HOLD_LIMIT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = |gnt_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 3'b000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_tri_mux_rr_arbiter.sv
// Directed bench for tri_mux_rr_arbiter with MAX_HOLD=4: reset, single owner,
// round-robin hand-over, preemption, saturation and reset during a grant.
module tb_tri_mux_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  tri_mux_rr_arbiter_if bus_if ();

  tri_mux_rr_arbiter #(.MAX_HOLD(4), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] g, input logic [1:0] s, input logic b);
    check({tag, ".gnt"}, {5'd0, bus_if.gnt}, {5'd0, g});
    check({tag, ".sel"}, {6'd0, bus_if.sel}, {6'd0, s});
    check({tag, ".busy"}, {7'd0, bus_if.busy}, {7'd0, b});
  endtask

  task automatic do_reset(input logic [2:0] r);
    bus_if.req = r;
    rst_n = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.req = 3'b111;

    // 1. Reset with all requests pending, released mid-cycle.
    step();
    step();
    check_out("rst_hold", 3'b000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_out("rst_first", 3'b001, 2'd0, 1'b1);

    // 2. Single requester: release to idle, then three cycles of i1.
    bus_if.req = 3'b000;
    step();
    check_out("idle0", 3'b000, 2'd0, 1'b0);
    bus_if.req = 3'b010;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("single%0d", i), 3'b010, 2'd1, 1'b1);
    end
    bus_if.req = 3'b000;
    step();
    check_out("single_idle", 3'b000, 2'd1, 1'b0);

    // 3. Round-robin hand-over with back-to-back grants.
    do_reset(3'b111);
    step(); check_out("rr_a0", 3'b001, 2'd0, 1'b1);
    step(); check_out("rr_a1", 3'b001, 2'd0, 1'b1);
    bus_if.req = 3'b110;
    step(); check_out("rr_b0", 3'b010, 2'd1, 1'b1);
    bus_if.req = 3'b111;
    step(); check_out("rr_b1", 3'b010, 2'd1, 1'b1);
    bus_if.req = 3'b101;
    step(); check_out("rr_c0", 3'b100, 2'd2, 1'b1);
    bus_if.req = 3'b111;
    step(); check_out("rr_c1", 3'b100, 2'd2, 1'b1);
    bus_if.req = 3'b011;
    step(); check_out("rr_d0", 3'b001, 2'd0, 1'b1);

    // 4. Preemption: i0 and i1 alternate every 4 cycles.
    do_reset(3'b011);
    for (int i = 0; i < 12; i++) begin
      logic [2:0] g_exp;
      logic [1:0] s_exp;
      g_exp = ((i / 4) % 2 == 0) ? 3'b001 : 3'b010;
      s_exp = ((i / 4) % 2 == 0) ? 2'd0 : 2'd1;
      step();
      check_out($sformatf("preempt%0d", i), g_exp, s_exp, 1'b1);
    end

    // 5. No competitor: i2 holds for 20 cycles, counter saturates at 4.
    do_reset(3'b100);
    for (int i = 0; i < 20; i++) begin
      step();
      check_out($sformatf("solo%0d", i), 3'b100, 2'd2, 1'b1);
    end
    check("solo_cnt_sat", dut.cnt_q, 8'd4);
    bus_if.req = 3'b101;
    step();
    check_out("solo_preempt", 3'b001, 2'd0, 1'b1);

    // 6. Reset during the 2nd cycle of a grant to i1 (ptr moved to 1 first).
    do_reset(3'b001);
    step(); check_out("mid_g0", 3'b001, 2'd0, 1'b1);
    bus_if.req = 3'b010;
    step(); check_out("mid_g1a", 3'b010, 2'd1, 1'b1);
    step(); check_out("mid_g1b", 3'b010, 2'd1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_async", 3'b000, 2'd0, 1'b0);
    check("mid_ptr", {6'd0, dut.ptr_q}, 8'd0);
    bus_if.req = 3'b110;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_out("mid_after", 3'b010, 2'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tri_mux_rr_arbiter.md
Name: tri_mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 3:1 mux datapath between three requesters (mux inputs i0, i1, i2).
- Drives the mux select pair from a registered 2-bit select and returns a one-hot grant to the winner.
- Enforces a maximum hold time, so one requester cannot starve the other two.
- Sits directly in front of the 3:1 mux select inputs (s1 = sel[1], s0 = sel[0]).

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant while another requester is pending. Legal range is 1 to 255.
- CW, 8: width of the hold counter. Must be able to represent MAX_HOLD.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  3  request vector; req[n] asks for mux input n. Level-sensitive; held high for as long as the requester wants the grant.
- gnt  output  3  registered one-hot grant, or all zero when idle.
- sel  output  2  registered mux select: 00 selects i0, 01 selects i1, 10 selects i2. The value 11 never occurs.
- busy  output  1  registered; equals |gnt.

Behaviour:
Reset (asynchronous, rst_n low):
- gnt=000, sel=00, busy=0.
- Internal state: state=IDLE, ptr=0, cnt=0.
- Reset may assert in any cycle. A grant in progress is dropped immediately with no completion.
- After rst_n deasserts, the first arbitration uses ptr=0.

Arbitration function:
- Search order is ptr, ptr+1, ptr+2, modulo 3.
- The first index with its req bit set wins.

State IDLE:
- gnt=000. sel keeps its last value so the mux output stays stable.
- On an edge with req != 000: grant the winner (gnt=onehot(w), sel=w, busy=1), set cnt=1, go to GRANT.
- Latency is 1 cycle from req sampled high to gnt high.

State GRANT (owner o), evaluated each edge in priority order:
1. req[o]=0 (release):
   - Set ptr=(o+1) mod 3.
   - Arbitrate the remaining requests using the new ptr.
   - If there is a winner, grant it on the same edge (back-to-back, no idle cycle) and set cnt=1.
   - If there is no winner, go to IDLE with gnt=000 and busy=0.
2. req[o]=1, cnt==MAX_HOLD, and another req bit is set (preempt):
   - Set ptr=(o+1) mod 3.
   - Grant the arbitration winner, excluding o, and set cnt=1.
   - The previous owner loses the grant even though its req is still high. It is re-served in round-robin order.
3. req[o]=1, otherwise (hold):
   - Grant unchanged.
   - cnt increments and saturates at MAX_HOLD.
   - With no competitor, the owner keeps the grant indefinitely.

Invariants:
- gnt is always one-hot or zero.
- sel equals the encoded index of gnt whenever busy=1.
- sel and gnt change only on clock edges, so the mux select is glitch-free.
- A requester that drops req while not granted is simply not considered.
- A requester raising req in the same cycle as a release is eligible in that cycle's arbitration.
- ptr updates only on a release or a preemption, never while in IDLE.
- Hold bound: with competition present, an owner keeps gnt for at most MAX_HOLD consecutive cycles.

Test Plan (MAX_HOLD=4 unless stated):
1. Reset: hold rst_n=0 with req=111, then deassert it mid-cycle → gnt=000, sel=00, busy=0 while in reset; gnt=001, sel=00 one edge after release.
2. Single requester: req=010 for 3 cycles, then 000 → gnt=010 and sel=01 for 3 cycles starting 1 cycle after req rises; then gnt=000, busy=0, sel stays 01.
3. Round-robin: from reset, req=111 held, with each owner dropping its bit for 1 cycle after 2 grant cycles → grant order 001, 010, 100, 001, back-to-back with no idle cycle; sel sequence 00, 01, 10, 00.
4. Preemption: req=011 held constantly → gnt=001 for exactly 4 cycles, then 010 for 4 cycles, then 001, repeating.
5. No competitor: req=100 held for 20 cycles → gnt=100 and sel=10 for all 20 cycles with no timeout drop; cnt saturates at 4.
6. Reset mid-grant: assert rst_n=0 during the 2nd cycle of a grant to 010 → gnt=000 immediately (asynchronously, before the next edge); after release with req=110, the grant goes to 010 because ptr was reset to 0.
